xoroshiro128_gen: RTL and testbench
===================================

// Module: xoroshiro128_gen
// PURPOSE
//  Parametrised xoroshiro128 PRNG. Successor of the single-mode seed/step generator.
//  Adds selectable scrambler (+, ++, **), truncated output width and a valid/ready
//  output handshake. The state steps only when a word is consumed.
//  Feeds the elliptic-curve scalar/nonce datapath and any block that needs a gated random stream.
// PARAMETERS
//  OUT_W    64  output width, 1..64; out_data = upper OUT_W bits of the scrambled word
//  ROT_A    55  state rotation a (s0 rotl a)
//  SHF_B    14  state shift b (s1 << b)
//  ROT_C    36  state rotation c (s1 rotl c)
//  ZSEED    64'h9E3779B97F4A7C15  s0 substituted when both seeds are zero
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous reset, active low
//  load       in   1      load seed1/seed2 (highest priority)
//  seed1      in   64     s0 seed
//  seed2      in   64     s1 seed
//  mode       in   2      0:+ (s0+s1)  1:++ rotl(s0+s1,17)+s0  2:** rotl(s0*5,7)*9  3:reserved=+
//  out_valid  out  1      out_data holds an unconsumed word
//  out_ready  in   1      consumer accepts out_data when out_valid&out_ready
//  out_data   out  OUT_W  scrambled word
//  jump_req   in   1      request 2^64-step jump (JUMP_EN only)
//  busy       out  1      jump in progress (JUMP_EN only, else 0)
// BEHAVIOUR
//  - Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
//  - Reset: s0=ZSEED, s1=0, out_valid=0, out_data=0, busy=0, jump FSM IDLE.
//  - Step: t=s0^s1; s0'=rotl(s0,ROT_A)^t^(t<<SHF_B); s1'=rotl(t,ROT_C). All arithmetic is mod 2^64.
//  - Invariant: out_data = f_mode(state), registered whenever the state is written.
//  - load=1 at edge N:
//    - state <= seeds, or {ZSEED,0} if both seeds are 0.
//    - out_data <= f_mode(loaded state).
//    - out_valid=1 from N+1.
//    - load aborts any jump: busy=0 and the FSM goes to IDLE.
//  - Accept (out_valid&out_ready, no load):
//    - state <= step(state); out_data <= f_mode(step(state)) in the same edge.
//    - out_valid stays 1. Throughput is 1 word/clk.
//  - Backpressure: while out_valid & !out_ready, out_data and the state are frozen.
//  - The first word after reset is not valid until a load.
//  - mode is sampled only at load/accept/jump-complete; a mode change never alters a held out_data.
//  - Truncation: out_data = word[63 -: OUT_W].
// CONFIGURATION
//  - XOROSHIRO_JUMP_EN defined: jump engine present.
//    - FSM IDLE->JUMP->IDLE.
//    - jump_req in IDLE, with no load: busy=1, out_valid=0, acc=0, idx=0.
//    - Each JUMP cycle: if K[idx]=1, acc ^= state; then state=step(state); idx++.
//    - K = {64'hD86B048B86AA9922, 64'hBEAC0467EBA5FACB}; bit 0 is the LSB of the low word (0xBEAC...).
//    - After 128 cycles: state <= acc, out_data <= f_mode(acc), out_valid=1, busy=0.
//    - jump_req while busy or out of IDLE is ignored. K is valid only for the default ROT_A/SHF_B/ROT_C.
//  - Not defined: no jump logic; jump_req ignored; busy tied 0.
// TESTING
//  1. Reset then load seed1=1, seed2=2, mode=0, out_ready=1:
//     out_data=64'h3, then 64'h008000300000C003 on the next clk.
//  2. load seed1=1, seed2=2 with mode=1 -> 64'h60001. With mode=2 -> 64'h1680.
//  3. load seeds 0/0, mode=0 -> out_data=64'h9E3779B97F4A7C15.
//     Next accept yields f(step(ZSEED,0)), never 0.
//  4. After seed 1/2 load, out_ready=0 for 10 clks: out_data stays 64'h3 and out_valid stays 1.
//     Raise out_ready: next word 64'h008000300000C003.
//  5. OUT_W=32, seed 1/2, mode=0: out_data=32'h0, then 32'h00800030.
//  6. JUMP_EN, seed 1/2:
//     - jump_req: busy=1 for exactly 128 clks, then out_valid=1 and state matches the C reference jump().
//     - load at cycle 50 of the jump: busy=0 next clk, out_data=64'h3.

Source files
------------

// File: rtl/xoroshiro128_gen.sv
// xoroshiro128 PRNG with selectable scrambler (+, ++, **), truncated output and valid/ready output.
// Define XOROSHIRO_JUMP_EN to include the 2^64-step jump engine.
module xoroshiro128_gen #(
  parameter int          OUT_W = 64,
  parameter int          ROT_A = 55,
  parameter int          SHF_B = 14,
  parameter int          ROT_C = 36,
  parameter logic [63:0] ZSEED = 64'h9E3779B97F4A7C15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [63:0]      seed1,
  input  logic [63:0]      seed2,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             jump_req,
  output logic             busy
);

  // Handshake: a word transfers on a rising edge where out_valid && out_ready;
  // out_valid never drops without a transfer except when a jump starts.

  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [127:0] step(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] t;
    t = a ^ b;
    return {rotl(a, ROT_A) ^ t ^ (t << SHF_B), rotl(t, ROT_C)};
  endfunction

  function automatic logic [OUT_W-1:0] scramble(input logic [1:0] m, input logic [63:0] a,
                                                input logic [63:0] b);
    logic [63:0] w;
    case (m)
      2'd1:    w = rotl(a + b, 17) + a;
      2'd2:    w = rotl(a * 64'd5, 7) * 64'd9;
      default: w = a + b;
    endcase
    return w[63 -: OUT_W];
  endfunction

  logic [63:0]      s0, s1, s0_nxt, s1_nxt;
  logic             valid_nxt, wr;
  logic [OUT_W-1:0] data_nxt;
  logic             seeds_zero;

  assign seeds_zero = (seed1 == 64'd0) && (seed2 == 64'd0);

`ifdef XOROSHIRO_JUMP_EN
  // Bit i of the jump polynomial selects whether step i's state joins the accumulator.
  localparam logic [127:0] JUMP_K = {64'hD86B048B86AA9922, 64'hBEAC0467EBA5FACB};

  typedef enum logic {IDLE, JUMP} jump_state_t;
  jump_state_t jstate, jstate_nxt;
  logic [63:0] acc0, acc1, acc0_nxt, acc1_nxt, mix0, mix1;
  logic [6:0]  idx, idx_nxt;

  assign busy = (jstate == JUMP);
`else
  logic unused_jump_req;
  assign unused_jump_req = jump_req;
  assign busy = 1'b0;
`endif

  always_comb begin
    s0_nxt    = s0;
    s1_nxt    = s1;
    valid_nxt = out_valid;
    wr        = 1'b0;
`ifdef XOROSHIRO_JUMP_EN
    jstate_nxt = jstate;
    acc0_nxt   = acc0;
    acc1_nxt   = acc1;
    idx_nxt    = idx;
    mix0       = acc0 ^ (JUMP_K[idx] ? s0 : 64'd0);
    mix1       = acc1 ^ (JUMP_K[idx] ? s1 : 64'd0);
`endif
    if (load) begin
      s0_nxt    = seeds_zero ? ZSEED : seed1;
      s1_nxt    = seed2;
      valid_nxt = 1'b1;
      wr        = 1'b1;
`ifdef XOROSHIRO_JUMP_EN
      jstate_nxt = IDLE;
`endif
    end
`ifdef XOROSHIRO_JUMP_EN
    else if (jstate == JUMP) begin
      if (idx == 7'd127) begin
        s0_nxt     = mix0;
        s1_nxt     = mix1;
        valid_nxt  = 1'b1;
        wr         = 1'b1;
        jstate_nxt = IDLE;
      end else begin
        {s0_nxt, s1_nxt} = step(s0, s1);
        acc0_nxt = mix0;
        acc1_nxt = mix1;
        idx_nxt  = idx + 7'd1;
      end
    end else if (jump_req) begin
      jstate_nxt = JUMP;
      valid_nxt  = 1'b0;
      acc0_nxt   = 64'd0;
      acc1_nxt   = 64'd0;
      idx_nxt    = 7'd0;
    end
`endif
    else if (out_valid && out_ready) begin
      {s0_nxt, s1_nxt} = step(s0, s1);
      wr = 1'b1;
    end
  end

  // out_data tracks the state: it is rewritten exactly when the state is.
  assign data_nxt = wr ? scramble(mode, s0_nxt, s1_nxt) : out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0        <= ZSEED;
      s1        <= 64'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef XOROSHIRO_JUMP_EN
      jstate <= IDLE;
      acc0   <= 64'd0;
      acc1   <= 64'd0;
      idx    <= 7'd0;
`endif
    end else begin
      s0        <= s0_nxt;
      s1        <= s1_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
`ifdef XOROSHIRO_JUMP_EN
      jstate <= jstate_nxt;
      acc0   <= acc0_nxt;
      acc1   <= acc1_nxt;
      idx    <= idx_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_xoroshiro128_gen.sv
// Bench for xoroshiro128_gen: directed vectors plus random load/ready/mode/jump traffic
// against a C-style reference model; a 32-bit-output instance shares the same inputs.
module tb_xoroshiro128_gen;

  localparam logic [63:0] ZSEED = 64'h9E3779B97F4A7C15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [63:0] seed1 = 64'd0;
  logic [63:0] seed2 = 64'd0;
  logic [1:0]  mode = 2'd0;
  logic        out_ready = 1'b0;
  logic        jump_req = 1'b0;
  logic        out_valid, busy, out_valid32, busy32;
  logic [63:0] out_data;
  logic [31:0] out_data32;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [63:0] ms0, ms1, m_word, jt0, jt1;
  logic        m_valid;
  int          m_jcnt;
  logic [63:0] exp_q[$];

  xoroshiro128_gen dut (
    .clk(clk), .rst_n(rst_n), .load(load), .seed1(seed1), .seed2(seed2), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .jump_req(jump_req), .busy(busy)
  );

  xoroshiro128_gen #(.OUT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .load(load), .seed1(seed1), .seed2(seed2), .mode(mode),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
    .jump_req(jump_req), .busy(busy32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_rotl(input logic [63:0] x, input int k);
    logic [127:0] d;
    d = {x, x};
    return d[127 - k -: 64];
  endfunction

  // Reference next(): s[1] ^= s[0]; s[0] = rotl(s0,55) ^ s1 ^ (s1<<14); s[1] = rotl(s1,36)
  function automatic logic [127:0] ref_next(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x1;
    x1 = b ^ a;
    return {ref_rotl(a, 55) ^ x1 ^ (x1 * 64'd16384), ref_rotl(x1, 36)};
  endfunction

  function automatic logic [63:0] ref_word(input logic [1:0] m, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [63:0] p;
    if (m == 2'd1) return ref_rotl(a + b, 17) + a;
    if (m == 2'd2) begin
      p = a * 64'd5;
      return ref_rotl(p, 7) * 64'd9;
    end
    return a + b;
  endfunction

  function automatic logic [127:0] ref_jump(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] kw[2];
    logic [63:0] x0, x1, c0, c1;
    kw[0] = 64'hBEAC0467EBA5FACB;
    kw[1] = 64'hD86B048B86AA9922;
    x0 = 64'd0; x1 = 64'd0; c0 = a; c1 = b;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++) begin
        if (kw[i][j]) begin
          x0 ^= c0;
          x1 ^= c1;
        end
        {c0, c1} = ref_next(c0, c1);
      end
    return {x0, x1};
  endfunction

  task automatic model_reset();
    ms0 = ZSEED; ms1 = 64'd0; m_word = 64'd0; m_valid = 1'b0; m_jcnt = 0;
    exp_q.delete();
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (load) begin
      ms0 = (seed1 == 64'd0 && seed2 == 64'd0) ? ZSEED : seed1;
      ms1 = seed2;
      m_word = ref_word(mode, ms0, ms1);
      m_valid = 1'b1;
      m_jcnt = 0;
    end else if (m_jcnt > 0) begin
      m_jcnt--;
      if (m_jcnt == 0) begin
        ms0 = jt0; ms1 = jt1;
        m_word = ref_word(mode, ms0, ms1);
        m_valid = 1'b1;
      end
    end
`ifdef XOROSHIRO_JUMP_EN
    else if (jump_req) begin
      {jt0, jt1} = ref_jump(ms0, ms1);
      m_jcnt = 128;
      m_valid = 1'b0;
    end
`endif
    else if (m_valid && out_ready) begin
      exp_q.push_back(m_word);
      {ms0, ms1} = ref_next(ms0, ms1);
      m_word = ref_word(mode, ms0, ms1);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, {63'd0, out_valid}, {63'd0, m_valid});
    check({tag, "_data"}, out_data, m_word);
    check({tag, "_busy"}, {63'd0, busy}, {63'd0, m_jcnt > 0});
    check({tag, "_valid32"}, {63'd0, out_valid32}, {63'd0, m_valid});
    check({tag, "_data32"}, {32'd0, out_data32}, {32'd0, m_word[63:32]});
  endtask

  task automatic tick(input string tag);
    logic        dut_acc;
    logic [63:0] got;
    dut_acc = out_valid && out_ready && !load;
`ifdef XOROSHIRO_JUMP_EN
    if (jump_req && !busy) dut_acc = 1'b0;
`endif
    got = out_data;
    model_step();
    @(posedge clk);
    #1;
    if (dut_acc) begin
      if (exp_q.size() == 0) check({tag, "_sb_extra"}, 64'd1, 64'd0);
      else check({tag, "_sb_word"}, got, exp_q.pop_front());
    end
    check_outputs(tag);
  endtask

  task automatic do_load(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m);
    seed1 = a; seed2 = b; mode = m; load = 1'b1;
    tick("load");
    load = 1'b0;
  endtask

  initial begin
    int blen;
    model_reset();
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    #12 rst_n = 1'b1;

    // No valid word before the first load, even with the consumer ready
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick("preload");

    // Seed 1/2, '+' scrambler, full and truncated widths
    do_load(64'd1, 64'd2, 2'd0);
    check("t1_w0", out_data, 64'h3);
    check("t5_w0", {32'd0, out_data32}, 64'h0);
    tick("t1");
    check("t1_w1", out_data, 64'h008000300000C003);
    check("t5_w1", {32'd0, out_data32}, 64'h00800030);

    // '++' and '**' scramblers
    out_ready = 1'b0;
    do_load(64'd1, 64'd2, 2'd1);
    check("t2_pp", out_data, 64'h60001);
    do_load(64'd1, 64'd2, 2'd2);
    check("t2_ss", out_data, 64'h1680);

    // All-zero seed substitution
    do_load(64'd0, 64'd0, 2'd0);
    check("t3_z", out_data, ZSEED);
    out_ready = 1'b1;
    tick("t3");
    check("t3_nz", {63'd0, out_data != 64'd0}, 64'd1);

    // Backpressure holds the word regardless of mode changes
    out_ready = 1'b0;
    do_load(64'd1, 64'd2, 2'd0);
    for (int i = 0; i < 10; i++) begin
      mode = 2'($urandom_range(0, 3));
      tick("t4_hold");
      check("t4_held", out_data, 64'h3);
      check("t4_v", {63'd0, out_valid}, 64'd1);
    end
    mode = 2'd0;
    out_ready = 1'b1;
    tick("t4");
    check("t4_next", out_data, 64'h008000300000C003);

`ifdef XOROSHIRO_JUMP_EN
    // Full jump: busy for exactly 128 clocks, then the jumped state's word
    out_ready = 1'b0;
    do_load(64'd1, 64'd2, 2'd0);
    jump_req = 1'b1;
    tick("t6_req");
    jump_req = 1'b0;
    blen = busy ? 1 : 0;
    while (busy && blen < 200) begin
      tick("t6_run");
      if (busy) blen++;
    end
    check("t6_busy_len", 64'(blen), 64'd128);
    check("t6_valid", {63'd0, out_valid}, 64'd1);
    check("t6_word", out_data, ref_word(2'd0, ref_jump(64'd1, 64'd2) >> 64,
                                        ref_jump(64'd1, 64'd2) & {64'd0, {64{1'b1}}}));
    // Load during a jump aborts it
    jump_req = 1'b1;
    tick("t6b_req");
    jump_req = 1'b0;
    for (int i = 0; i < 49; i++) tick("t6b_run");
    check("t6b_busy_mid", {63'd0, busy}, 64'd1);
    do_load(64'd1, 64'd2, 2'd0);
    check("t6b_busy", {63'd0, busy}, 64'd0);
    check("t6b_data", out_data, 64'h3);
`else
    jump_req = 1'b1;
    tick("nojump");
    jump_req = 1'b0;
    check("nojump_busy", {63'd0, busy}, 64'd0);
    check("nojump_valid", {63'd0, out_valid}, 64'd1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        seed1 = 64'd0; seed2 = 64'd0;
      end else begin
        seed1 = {$urandom, $urandom};
        seed2 = {$urandom, $urandom};
      end
      mode = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      jump_req = ($urandom_range(0, 299) == 0);
      tick("rnd");
      if (i == 1500) begin
        load = 1'b0; jump_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_data", out_data, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        #1 rst_n = 1'b1;
      end
    end
    load = 1'b0; jump_req = 1'b0;

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
